// File: rtl/mic_frame_buffer_pkg.sv
// Shared types and helpers for the microphone frame buffer.
// Holds parameter defaults, the read-side state enum and abs saturation.
package mic_frame_buffer_pkg;

  localparam int QBIT_DEF  = 16;
  localparam int DEPTH_DEF = 16;
  localparam int CNTW_DEF  = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } fb_state_t;

  // Magnitude of a sign-extended qbit-wide sample; the most
  // negative code has no positive twin, so it clamps to max.
  function automatic logic [31:0] abs_sat(
    input logic signed [31:0] x,
    input int                 qbit
  );
    logic signed [31:0] lo;
    lo = -(32'sd1 <<< (qbit - 1));
    if (x == lo)
      abs_sat = (32'd1 << (qbit - 1)) - 32'd1;
    else if (x < 0)
      abs_sat = -x;
    else
      abs_sat = x;
  endfunction

endpackage

// File: rtl/mic_frame_buffer_sample_bank.sv
// Two-bank sample store: one write port, one registered read port.
// Reads see a same-cycle write to the same word (bank swap case).
module sample_bank #(
  parameter int QBIT  = 16,
  parameter int DEPTH = 16
)(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic                     wsel,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [QBIT-1:0]          wdata,
  input  logic                     rsel,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [QBIT-1:0]          rdata
);

  logic [QBIT-1:0] mem [2*DEPTH];

  logic hit;

  // A write landing on the word being read this cycle
  assign hit = we && (wsel == rsel) && (waddr == raddr);

  // Sample storage, contents left unreset
  always_ff @(posedge clk) begin
    if (we)
      mem[{wsel, waddr}] <= wdata;
  end

  // Registered read with write bypass
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      rdata <= '0;
    else if (hit)
      rdata <= wdata;
    else
      rdata <= mem[{rsel, raddr}];
  end

endmodule

// File: rtl/mic_frame_buffer.sv
// Ping-pong frame buffer for decimated microphone samples.
// Fills one bank while the consumer reads the other.
module mic_frame_buffer
  import mic_frame_buffer_pkg::*;
#(
  parameter int QBIT  = QBIT_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNTW  = CNTW_DEF
)(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     dv,
  input  logic signed [QBIT-1:0]   dat_i,
  output logic                     frame_valid,
  input  logic                     frame_ack,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [QBIT-1:0]          rd_data,
  output logic [QBIT-1:0]          peak,
  output logic                     overrun,
  input  logic                     clr_ovr,
  output logic [CNTW-1:0]          frame_cnt
);

  localparam int AW = $clog2(DEPTH);

  fb_state_t       state;
  logic            dv_q;
  logic [AW-1:0]   idx;
  logic [QBIT-1:0] run_pk;
  logic            wr_bank;

  logic            qual;
  logic            last;
  logic            swap;
  logic [QBIT-1:0] cur_abs;
  logic [QBIT-1:0] new_peak;
  logic            rd_sel;

  // Edge qualify, frame completion and next read-bank select
  always_comb begin
    qual     = dv & ~dv_q;
    last     = qual && (idx == AW'(DEPTH - 1));
    swap     = last && ((state == EMPTY) || frame_ack);
    cur_abs  = QBIT'(abs_sat(32'(dat_i), QBIT));
    new_peak = (cur_abs > run_pk) ? cur_abs : run_pk;
    rd_sel   = swap ? wr_bank : ~wr_bank;
  end

  // Write side: dv history, fill index and running peak
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dv_q   <= 1'b0;
      idx    <= '0;
      run_pk <= '0;
    end else begin
      dv_q <= dv;
      if (qual) begin
        idx <= idx + AW'(1);
        if (last)
          run_pk <= '0;
        else
          run_pk <= new_peak;
      end
    end
  end

  // Read-side FSM with registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= EMPTY;
      wr_bank     <= 1'b0;
      frame_valid <= 1'b0;
      peak        <= '0;
      frame_cnt   <= '0;
      overrun     <= 1'b0;
    end else begin
      if (clr_ovr)
        overrun <= 1'b0;
      if (swap) begin
        wr_bank     <= ~wr_bank;
        frame_valid <= 1'b1;
        peak        <= new_peak;
        frame_cnt   <= frame_cnt + CNTW'(1);
        state       <= HOLD;
      end else begin
        unique case (state)
          EMPTY: begin
            state <= EMPTY;
          end
          HOLD: begin
            if (last) begin
              overrun <= 1'b1;
            end else if (frame_ack) begin
              frame_valid <= 1'b0;
              state       <= EMPTY;
            end
          end
        endcase
      end
    end
  end

  sample_bank #(
    .QBIT  (QBIT),
    .DEPTH (DEPTH)
  ) u_bank (
    .clk   (clk),
    .reset (reset),
    .we    (qual),
    .wsel  (wr_bank),
    .waddr (idx),
    .wdata (dat_i),
    .rsel  (rd_sel),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule

// File: doc/mic_frame_buffer.md
MIC_FRAME_BUFFER -- requirements
Module: mic_frame_buffer

Interface
REQ-001 The block SHALL have parameter QBIT, default 16, meaning sample width in bits (signed two's complement).
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning samples per frame (power of two, 2..1024).
REQ-003 The block SHALL have parameter CNTW, default 16, meaning frame counter width.
REQ-004 The block SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, meaning asynchronous active-low reset: assert on the falling edge, release synchronously to clk.
REQ-006 The block SHALL have port dv, input, 1, meaning sample-valid level from the PDM decimator; only a 0->1 transition qualifies a sample.
REQ-007 The block SHALL have port dat_i, input, QBIT, meaning signed sample, sampled in the cycle dv is first seen high.
REQ-008 The block SHALL have port frame_valid, output, 1, meaning a completed frame is held in the read bank.
REQ-009 The block SHALL have port frame_ack, input, 1, meaning the consumer releases the read bank.
REQ-010 The block SHALL have port rd_addr, input, log2(DEPTH), meaning sample index into the read bank.
REQ-011 The block SHALL have port rd_data, output, QBIT, meaning registered read-bank sample.
REQ-012 The block SHALL have port peak, output, QBIT, meaning saturated absolute peak of the frame in the read bank.
REQ-013 The block SHALL have port overrun, output, 1, meaning sticky flag that a frame was discarded.
REQ-014 The block SHALL have port clr_ovr, input, 1, meaning synchronous clear of overrun.
REQ-015 The block SHALL have port frame_cnt, output, CNTW, meaning count of frames delivered; it wraps modulo 2^CNTW.

Function
REQ-016 The block SHALL detect the dv rising edge with a one-register history, so that a dv held high for N cycles yields exactly one sample.
REQ-017 On each qualified edge the block SHALL write dat_i to write-bank[idx] and increment idx; idx wraps from DEPTH-1 to 0.
REQ-018 The block SHALL keep a running peak per frame: |dat_i| compared against the running peak, with -2^(QBIT-1) saturated to 2^(QBIT-1)-1; the running peak is cleared when each frame starts.
REQ-019 The read-side FSM SHALL have two states: EMPTY (frame_valid=0) and HOLD (frame_valid=1).
REQ-020 When the DEPTH-th sample is written and the FSM is in EMPTY, the block SHALL, on the next edge, swap banks, set frame_valid=1, latch peak including that sample, increment frame_cnt, and enter HOLD.
REQ-021 In HOLD, frame_ack=1 SHALL clear frame_valid on the next edge and move the FSM to EMPTY.
REQ-022 frame_ack in EMPTY SHALL be ignored.
REQ-023 If frame completion and frame_ack occur in the same cycle in HOLD, completion SHALL win: banks swap, frame_valid stays 1, frame_cnt increments, and overrun is unchanged.
REQ-024 If a frame completes in HOLD without frame_ack, the block SHALL discard the frame: set overrun=1, leave the read bank, peak and frame_cnt unchanged, and restart filling at idx 0.
REQ-025 clr_ovr SHALL clear overrun on the next edge; a simultaneous new overrun event SHALL win and keep overrun at 1.
REQ-026 rd_data SHALL equal read-bank[rd_addr] one cycle after rd_addr is presented.
REQ-027 The read-bank contents SHALL be stable throughout HOLD.
REQ-028 rd_data after a bank swap SHALL reflect the new read bank from the cycle frame_valid rises.

Reset
REQ-029 While reset=0, the block SHALL hold frame_valid=0, rd_data=0, peak=0, overrun=0, frame_cnt=0, idx=0, running peak=0, dv history=0, and FSM=EMPTY.
REQ-030 A reset mid-frame SHALL discard the partial frame; the first frame after release SHALL require DEPTH fresh qualified edges.
REQ-031 Bank RAM contents SHALL NOT be required to reset.

Structure
REQ-032 A shared package SHALL hold the QBIT and DEPTH defaults, the FSM state enum (EMPTY, HOLD), and the abs-saturate function.
REQ-033 The design SHALL use exactly one sub-module, sample_bank: a two-bank memory of 2xDEPTHxQBIT with one write port (bank select, idx) and one registered read port.

Verification (QBIT=16, DEPTH=4)
REQ-034 Scenario 1: 4 dv pulses with dat_i=1,-5,3,2 -> frame_valid=1 one cycle after the 4th edge; peak=5; frame_cnt=1; rd_addr=1 gives rd_data=16'hFFFB next cycle.
REQ-035 Scenario 2: dv held high for 10 cycles, then 3 more pulses -> exactly 4 samples stored; frame_valid rises once.
REQ-036 Scenario 3: a frame containing -32768 -> peak=32767.
REQ-037 Scenario 4: no ack, 4 more samples -> overrun=1; frame_cnt=1; rd_addr=1 still reads 16'hFFFB; clr_ovr -> overrun=0.
REQ-038 Scenario 5: frame_ack asserted in the same cycle as the 4th edge of frame 2 -> frame_valid stays 1; frame_cnt=2; overrun=0.
REQ-039 Scenario 6: reset asserted after 2 samples -> all outputs 0 immediately; after release, 3 samples leave frame_valid=0 and the 4th sets it.
